// File: rtl/mux2_1_pkg.sv
// Shared constants and types for the 16-bit two-way word selector.
package mux2_1_pkg;

  localparam int MUX2_1_WIDTH = 16;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef logic [MUX2_1_WIDTH-1:0] mux_word_t;

endpackage

// File: rtl/mux2_1_reg.sv
// WIDTH-wide D register with asynchronous active-low clear.
module mux2_1_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= '0;
    else        r_q <= d;
  end

  assign q = r_q;

endmodule

// File: rtl/mux2_1_unit.sv
// Two-way word selector: combinational o plus a one-cycle registered copy o_q.
// Optional feature macro MUX2_1_PARITY_EN adds o_par, the even parity of o_q.
module mux2_1_unit
  import mux2_1_pkg::*;
#(
  parameter int WIDTH = MUX2_1_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s0,
  output logic [WIDTH-1:0] o,
`ifdef MUX2_1_PARITY_EN
  output logic             o_par,
`endif
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] w_sel;

  // Plain ternary so an unknown select merges a/b like ordinary Verilog.
  assign w_sel = s0 ? b : a;
  assign o     = w_sel;

`ifdef MUX2_1_PARITY_EN
  logic [WIDTH:0] w_q;

  // Parity rides in the top bit so it clears and captures with the word.
  mux2_1_reg #(.WIDTH(WIDTH + 1)) u_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({^w_sel, w_sel}),
    .q     (w_q)
  );

  assign o_q   = w_q[WIDTH-1:0];
  assign o_par = w_q[WIDTH];
`else
  mux2_1_reg #(.WIDTH(WIDTH)) u_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (w_sel),
    .q     (o_q)
  );
`endif

endmodule

// File: tb/tb_mux2_1_unit.sv
// Scoreboard bench for mux2_1_unit; builds with or without MUX2_1_PARITY_EN.
module tb_mux2_1_unit;
  import mux2_1_pkg::*;

  localparam int W = MUX2_1_WIDTH;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a, b, o, o_q;
  logic         s0;
`ifdef MUX2_1_PARITY_EN
  logic         o_par;
`endif

  typedef struct packed {
    logic [W-1:0] word;
    logic         par;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mux2_1_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .s0    (s0),
    .o     (o),
`ifdef MUX2_1_PARITY_EN
    .o_par (o_par),
`endif
    .o_q   (o_q)
  );

  always #5 clk = ~clk;

  // Reference model: the selected word, and parity by counting ones.
  function automatic exp_t model(input logic sel, input logic [W-1:0] wa,
                                 input logic [W-1:0] wb);
    exp_t e;
    int   ones;
    e.word = (sel == SEL_B) ? wb : wa;
    ones = 0;
    for (int i = 0; i < W; i++) if (e.word[i] == 1'b1) ones++;
    e.par = ((ones % 2) == 1);
    return e;
  endfunction

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every cycle is valid, so each pending expectation is consumed per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("o_q", {16'h0, o_q}, {16'h0, e.word});
`ifdef MUX2_1_PARITY_EN
        check("o_par", {31'h0, o_par}, {31'h0, e.par});
`endif
      end
    end
  end

  task automatic drive(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs);
    exp_t e;
    @(posedge clk);
    #2;
    a  = va;
    b  = vb;
    s0 = vs;
    e  = model(vs, va, vb);
    #1;
    check("o_comb", {16'h0, o}, {16'h0, e.word});
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    a     = 16'd10;
    b     = 16'd12;
    s0    = 1'b0;
    #1;
    check("rst_o_q", {16'h0, o_q}, 32'h0);
    check("rst_o_valid", {16'h0, o}, 32'h000A);
`ifdef MUX2_1_PARITY_EN
    check("rst_o_par", {31'h0, o_par}, 32'h0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_hold_o_q", {16'h0, o_q}, 32'h0);
    #1;
    rst_n = 1'b1;

    drive(16'd10, 16'd12, 1'b0);
    drive(16'd10, 16'd12, 1'b1);

    for (int i = 0; i < 6; i++) drive(16'hFFFF, 16'h0000, i[0]);

    drive(16'h0007, 16'h0003, 1'b0);
    drive(16'h0007, 16'h0003, 1'b1);

    // Reset between edges while o_q holds 000C.
    drive(16'd10, 16'd12, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_o_q", {16'h0, o_q}, 32'h0);
    check("midrst_o", {16'h0, o}, 32'h000C);
`ifdef MUX2_1_PARITY_EN
    check("midrst_o_par", {31'h0, o_par}, 32'h0);
`endif
    @(posedge clk);
    #1;
    check("midrst_hold", {16'h0, o_q}, 32'h0);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(model(s0, a, b));

    // Select and data change together just before the edge.
    @(posedge clk);
    #2;
    a  = 16'h0001;
    b  = 16'h0002;
    s0 = 1'b0;
    #5;
    s0 = 1'b1;
    b  = 16'h1234;
    e  = model(s0, a, b);
    #1;
    check("late_o", {16'h0, o}, {16'h0, e.word});
    exp_q.push_back(e);

    repeat (40) drive(16'($urandom), 16'($urandom), 1'($urandom));

    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
